cnt_bank: RTL and testbench

Parametrised multi-channel counter bank, the successor to the fixed 8-bit single-register reset test counters. Each of NCH channels is a WIDTH-bit up/down counter with clear, load, per-channel direction, and an optional saturation mode. A snapshot/readout path lets a host sample all channels coherently. It sits in the reset/control test designs as a reusable counter primitive with a well-defined reset style.

---
 rtl/cnt_bank_pkg.sv | 26 ++
 rtl/cnt_bank_chan.sv | 114 +++++++++++
 rtl/cnt_bank.sv | 98 +++++++++
 tb/tb_cnt_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_bank_pkg
// Description : Shared constants, mode enum and helper function for the
//               cnt_bank multi-channel counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_bank_pkg;

    // Direction encoding on the per-channel dir input
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // Per-channel counting mode (sat input encoding)
    typedef enum logic {
        CNT_WRAP     = 1'b0,
        CNT_SATURATE = 1'b1
    } cnt_mode_e;

    // Width of the shadow read index; at least one bit even for one channel
    function automatic int cnt_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cnt_bank_pkg
`default_nettype wire

// File: rtl/cnt_bank_chan.sv
`default_nettype none
// ============================================================================
// Module      : cnt_bank_chan
// Description : Single WIDTH-bit up/down counter with CLR > LD > EN priority,
//               optional saturation (CNT_SAT_EN) and a registered one-cycle
//               terminal-count pulse.
// Configuration: CNT_SAT_EN builds the saturating path; otherwise the sat_i
//               input is ignored and the counter always wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_bank_chan
    import cnt_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             dir_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_hold_up;
    logic             w_hold_dn;
    logic             w_tc_up;
    logic             w_tc_dn;

    assign w_inc    = cnt_q + 1'b1;
    assign w_dec    = cnt_q - 1'b1;
    assign w_at_max = (cnt_q == c_max);
    assign w_at_min = (cnt_q == '0);

`ifdef CNT_SAT_EN
    cnt_mode_e w_mode;
    assign w_mode = cnt_mode_e'(sat_i);

    // Saturating channels hold at the limit and flag only the step that
    // lands on it; wrapping channels flag the step that rolls over.
    always_comb begin
        w_hold_up = 1'b0;
        w_hold_dn = 1'b0;
        w_tc_up   = w_at_max;
        w_tc_dn   = w_at_min;
        if (w_mode == CNT_SATURATE) begin
            w_hold_up = w_at_max;
            w_hold_dn = w_at_min;
            w_tc_up   = (w_inc == c_max);
            w_tc_dn   = (w_dec == '0);
        end
    end
`else
    // Wrap-only build: sat_i is accepted but has no effect
    logic w_sat_unused;
    assign w_sat_unused = sat_i;
    assign w_hold_up    = 1'b0;
    assign w_hold_dn    = 1'b0;
    assign w_tc_up      = w_at_max;
    assign w_tc_dn      = w_at_min;
`endif

    // Next-state selection: clear beats load beats count beats hold
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clr_i) begin
            cnt_d = RST_VAL;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            if (dir_i == CNT_UP) begin
                if (!w_hold_up) begin
                    cnt_d = w_inc;
                    tc_d  = w_tc_up;
                end
            end else begin
                if (!w_hold_dn) begin
                    cnt_d = w_dec;
                    tc_d  = w_tc_dn;
                end
            end
        end
    end

    // Counter and terminal-count registers; reset aborts any pending pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule : cnt_bank_chan
`default_nettype wire

// File: rtl/cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : cnt_bank
// Description : NCH-channel counter bank with coherent snapshot into shadow
//               registers and a registered indexed shadow readout.
// Configuration: CNT_SAT_EN enables per-channel saturation (see cnt_bank_chan).
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_bank
    import cnt_bank_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          WIDTH   = 8,
    parameter logic [31:0] RST_VAL = 32'd0,
    localparam int         IDXW    = cnt_idx_width(NCH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NCH-1:0]       en_i,
    input  logic [NCH-1:0]       clr_i,
    input  logic [NCH-1:0]       ld_i,
    input  logic [NCH*WIDTH-1:0] ld_val_i,
    input  logic [NCH-1:0]       dir_i,
    input  logic [NCH-1:0]       sat_i,
    input  logic                 snap_i,
    input  logic [IDXW-1:0]      rd_idx_i,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic                 rd_vld_o,
    output logic [NCH-1:0]       tc_o,
    output logic [NCH*WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] c_rst = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_vld_q;

    // One independent counter per channel
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        cnt_bank_chan #(
            .WIDTH   (WIDTH),
            .RST_VAL (c_rst)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (en_i[i]),
            .clr_i    (clr_i[i]),
            .ld_i     (ld_i[i]),
            .ld_val_i (ld_val_i[i*WIDTH +: WIDTH]),
            .dir_i    (dir_i[i]),
            .sat_i    (sat_i[i]),
            .cnt_o    (cnt_o[i*WIDTH +: WIDTH]),
            .tc_o     (tc_o[i])
        );
    end

    // Snapshot captures the registered (pre-update) counter values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= c_rst;
            end
        end else if (snap_i) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= cnt_o[i*WIDTH +: WIDTH];
            end
        end
    end

    // Readout mux; indices with no channel behind them read as zero
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_idx_i == IDXW'(i)) begin
                rd_data_d = shadow_q[i];
            end
        end
    end

    // Registered readout and sticky snapshot-taken flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            if (snap_i) begin
                rd_vld_q <= 1'b1;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_vld_o  = rd_vld_q;

endmodule : cnt_bank
`default_nettype wire

// File: tb/tb_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_bank
// Description : Directed self-checking bench for cnt_bank (NCH=4, WIDTH=8,
//               RST_VAL=5) plus a 3-channel instance for out-of-range reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_bank;

    localparam int K_CNT = 0;
    localparam int K_TC  = 1;
    localparam int K_RD  = 2;
    localparam int K_VLD = 3;
    localparam int K_RD3 = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en, clr, ld, dir, sat;
    logic [31:0] ld_val;
    logic        snap;
    logic [1:0]  rd_idx;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic [3:0]  tc;
    logic [31:0] cnt;

    logic [2:0]  en3, clr3, ld3, dir3, sat3;
    logic [23:0] ld_val3;
    logic [1:0]  rd_idx3;
    logic [7:0]  rd_data3;
    logic        rd_vld3;
    logic [2:0]  tc3;
    logic [23:0] cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          kind;
        int          ch;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    logic [7:0] sat_cnt [5];
    logic [3:0] sat_tc  [5];

    cnt_bank #(.NCH(4), .WIDTH(8), .RST_VAL(32'd5)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .ld_i(ld),
        .ld_val_i(ld_val), .dir_i(dir), .sat_i(sat), .snap_i(snap),
        .rd_idx_i(rd_idx), .rd_data_o(rd_data), .rd_vld_o(rd_vld),
        .tc_o(tc), .cnt_o(cnt)
    );

    cnt_bank #(.NCH(3), .WIDTH(8), .RST_VAL(32'd5)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en3), .clr_i(clr3), .ld_i(ld3),
        .ld_val_i(ld_val3), .dir_i(dir3), .sat_i(sat3), .snap_i(snap),
        .rd_idx_i(rd_idx3), .rd_data_o(rd_data3), .rd_vld_o(rd_vld3),
        .tc_o(tc3), .cnt_o(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int kind, int ch);
        case (kind)
            K_CNT:   return {24'd0, cnt[ch*8 +: 8]};
            K_TC:    return {28'd0, tc};
            K_RD:    return {24'd0, rd_data};
            K_VLD:   return {31'd0, rd_vld};
            default: return {24'd0, rd_data3};
        endcase
    endfunction

    task automatic expect_v(string tag, int kind, int ch, logic [31:0] e);
        exp_t item;
        item.tag  = tag;
        item.kind = kind;
        item.ch   = ch;
        item.exp  = e;
        sb.push_back(item);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.ch);
            n_tests++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ld(int ch, logic [7:0] v);
        ld_val[ch*8 +: 8] = v;
    endtask

    initial begin
`ifdef CNT_SAT_EN
        sat_cnt[0] = 8'hFE; sat_cnt[1] = 8'hFF; sat_cnt[2] = 8'hFF;
        sat_cnt[3] = 8'hFF; sat_cnt[4] = 8'hFF;
        sat_tc[0]  = 4'h0;  sat_tc[1]  = 4'h2;  sat_tc[2]  = 4'h0;
        sat_tc[3]  = 4'h0;  sat_tc[4]  = 4'h0;
`else
        sat_cnt[0] = 8'hFE; sat_cnt[1] = 8'hFF; sat_cnt[2] = 8'h00;
        sat_cnt[3] = 8'h01; sat_cnt[4] = 8'h02;
        sat_tc[0]  = 4'h0;  sat_tc[1]  = 4'h0;  sat_tc[2]  = 4'h2;
        sat_tc[3]  = 4'h0;  sat_tc[4]  = 4'h0;
`endif
        en = '0; clr = '0; ld = '0; dir = '0; sat = '0; ld_val = '0;
        snap = 1'b0; rd_idx = '0;
        en3 = '0; clr3 = '0; ld3 = '0; dir3 = '0; sat3 = '0; ld_val3 = '0;
        rd_idx3 = '0;

        // Power-on reset, checked with no clock edge
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) expect_v("rst_cnt", K_CNT, i, 32'h05);
        expect_v("rst_tc", K_TC, 0, 32'h0);
        expect_v("rst_rd", K_RD, 0, 32'h0);
        expect_v("rst_vld", K_VLD, 0, 32'h0);
        expect_v("rst_rd3", K_RD3, 0, 32'h0);
        check_all();
        @(negedge clk) rst_n = 1'b1;
        expect_v("idle_cnt0", K_CNT, 0, 32'h05);
        expect_v("idle_rd", K_RD, 0, 32'h05);
        expect_v("idle_vld", K_VLD, 0, 32'h0);
        tick();

        // Wrap up through FF->00, then down through 00->FF
        ld = 4'b0001; set_ld(0, 8'hFE);
        expect_v("wrap_ld", K_CNT, 0, 32'hFE);
        expect_v("wrap_ch1", K_CNT, 1, 32'h05);
        tick();
        ld = '0; en = 4'b0001; dir = 4'b0001;
        expect_v("wrap_ff", K_CNT, 0, 32'hFF); expect_v("wrap_tc_ff", K_TC, 0, 32'h0);
        tick();
        expect_v("wrap_00", K_CNT, 0, 32'h00); expect_v("wrap_tc_00", K_TC, 0, 32'h1);
        tick();
        expect_v("wrap_01", K_CNT, 0, 32'h01); expect_v("wrap_tc_01", K_TC, 0, 32'h0);
        tick();
        dir = 4'b0000;
        expect_v("down_00", K_CNT, 0, 32'h00); expect_v("down_tc_00", K_TC, 0, 32'h0);
        tick();
        expect_v("down_ff", K_CNT, 0, 32'hFF); expect_v("down_tc_ff", K_TC, 0, 32'h1);
        tick();
        en = '0;
        expect_v("hold_ff", K_CNT, 0, 32'hFF); expect_v("hold_tc", K_TC, 0, 32'h0);
        tick();

        // Saturation on ch1 (wraps in a build without saturation support)
        sat = 4'b0010; ld = 4'b0010; set_ld(1, 8'hFD);
        expect_v("sat_ld", K_CNT, 1, 32'hFD);
        tick();
        ld = '0; en = 4'b0010; dir = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            expect_v($sformatf("sat_cnt%0d", k), K_CNT, 1, {24'd0, sat_cnt[k]});
            expect_v($sformatf("sat_tc%0d", k), K_TC, 0, {28'd0, sat_tc[k]});
            tick();
        end
        en = '0; sat = '0;

        // Priority on ch2
        ld = 4'b0100; set_ld(2, 8'h77);
        expect_v("pri_pre", K_CNT, 2, 32'h77);
        tick();
        clr = 4'b0100; en = 4'b0100; dir = 4'b0100; set_ld(2, 8'h33);
        expect_v("pri_clr", K_CNT, 2, 32'h05); expect_v("pri_clr_tc", K_TC, 0, 32'h0);
        tick();
        clr = '0; en = '0; set_ld(2, 8'hFF);
        expect_v("pri_ldff", K_CNT, 2, 32'hFF);
        tick();
        en = 4'b0100; set_ld(2, 8'h00);
        expect_v("pri_ld00", K_CNT, 2, 32'h00); expect_v("pri_ld_tc", K_TC, 0, 32'h0);
        tick();
        set_ld(2, 8'h33);
        expect_v("pri_ld33", K_CNT, 2, 32'h33); expect_v("pri_ld33_tc", K_TC, 0, 32'h0);
        tick();
        ld = '0; en = '0; dir = '0;

        // Snapshot and readout
        ld = 4'b1111;
        set_ld(0, 8'd10); set_ld(1, 8'd20); set_ld(2, 8'd30); set_ld(3, 8'd40);
        expect_v("snp_ld3", K_CNT, 3, 32'd40);
        tick();
        ld = '0; snap = 1'b1; en = 4'b1111; dir = 4'b1111; rd_idx = 2'd0;
        expect_v("snp_cnt0", K_CNT, 0, 32'd11);
        expect_v("snp_cnt3", K_CNT, 3, 32'd41);
        expect_v("snp_rd_old", K_RD, 0, 32'h05);
        expect_v("snp_vld", K_VLD, 0, 32'h1);
        tick();
        snap = 1'b0; en = '0; rd_idx = 2'd2;
        expect_v("snp_rd2", K_RD, 0, 32'd30);
        tick();
        rd_idx = 2'd3;
        expect_v("snp_rd3", K_RD, 0, 32'd40);
        tick();
        snap = 1'b1; rd_idx = 2'd1;
        expect_v("snp_rd1_pre", K_RD, 0, 32'd20);
        tick();
        snap = 1'b0;
        expect_v("snp_rd1_new", K_RD, 0, 32'd21);
        expect_v("snp_vld_sticky", K_VLD, 0, 32'h1);
        tick();

        // Out-of-range index on the 3-channel instance
        rd_idx3 = 2'd2;
        expect_v("oor_rd2", K_RD3, 0, 32'h05);
        tick();
        rd_idx3 = 2'd3;
        expect_v("oor_rd3", K_RD3, 0, 32'h00);
        tick();

        // Reset mid-count while a TC pulse is showing
        ld = 4'b1001; set_ld(0, 8'hFE); set_ld(3, 8'h07);
        expect_v("mid_ld", K_CNT, 0, 32'hFE);
        tick();
        ld = '0; en = 4'b1001; dir = 4'b1001;
        expect_v("mid_ff", K_CNT, 0, 32'hFF);
        tick();
        expect_v("mid_00", K_CNT, 0, 32'h00); expect_v("mid_tc", K_TC, 0, 32'h1);
        expect_v("mid_ch3", K_CNT, 3, 32'h09);
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) expect_v("mid_rst_cnt", K_CNT, i, 32'h05);
        expect_v("mid_rst_tc", K_TC, 0, 32'h0);
        expect_v("mid_rst_rd", K_RD, 0, 32'h0);
        expect_v("mid_rst_vld", K_VLD, 0, 32'h0);
        check_all();
        en = '0; dir = '0;
        @(negedge clk) rst_n = 1'b1;
        expect_v("post_rst_cnt0", K_CNT, 0, 32'h05);
        expect_v("post_rst_tc", K_TC, 0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cnt_bank
`default_nettype wire
